// File: rtl/corevx_ptw_ml.sv
// corevx_ptw_ml -- parametrised multi-level page table walker.
//
// Translates a VPN to a leaf PPN by reading PTEs over an armleobus read
// master port. Supports bare-mode passthrough, A/D and store-dirty checks,
// walk abort, and reports the leaf level for superpage-aware TLB fill.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   m_transaction/m_cmd/m_address, m_transaction_response/_done, m_rdata
//                              armleobus read master (one PTE read at a time)
//   resolve_request/ack/abort/store, virtual_address, satp_mode, satp_ppn
//                              walk request side (sampled on accept)
//   resolve_done/pagefault/accessfault/access_bits/physical_address/level
//                              registered result; done and faults pulse in RESP
module corevx_ptw_ml #(
    parameter int LEVELS    = 2,
    parameter int VPN_BITS  = 10,
    parameter int PPN_WIDTH = 22,
    parameter int PTE_WIDTH = 32,
    parameter bit CHECK_AD  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          m_transaction,
    output logic [2:0]                    m_cmd,
    output logic [PPN_WIDTH+11:0]         m_address,
    input  logic [2:0]                    m_transaction_response,
    input  logic                          m_transaction_done,
    input  logic [PTE_WIDTH-1:0]          m_rdata,
    input  logic                          resolve_request,
    output logic                          resolve_ack,
    input  logic                          resolve_abort,
    input  logic                          resolve_store,
    input  logic [LEVELS*VPN_BITS-1:0]    virtual_address,
    input  logic                          satp_mode,
    input  logic [PPN_WIDTH-1:0]          satp_ppn,
    output logic                          resolve_done,
    output logic                          resolve_pagefault,
    output logic                          resolve_accessfault,
    output logic [7:0]                    resolve_access_bits,
    output logic [PPN_WIDTH-1:0]          resolve_physical_address,
    output logic [((LEVELS > 1) ? $clog2(LEVELS) : 1)-1:0] resolve_level
);
    localparam int LW        = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int VA_W      = LEVELS * VPN_BITS;
    localparam int PTE_SHIFT = $clog2(PTE_WIDTH / 8);
    localparam logic [2:0] CMD_READ     = 3'd1;
    localparam logic [2:0] RESP_SUCCESS = 3'd0;

    // A table must fill exactly one 4 KiB page.
    generate
        if (VPN_BITS + PTE_SHIFT != 12) begin : g_bad_cfg
            $error("corevx_ptw_ml: VPN_BITS + log2(PTE_WIDTH/8) must equal 12");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

    state_t                 state_q, state_d;
    logic [VA_W-1:0]        va_q, va_d;
    logic                   store_q, store_d;
    logic [LW-1:0]          level_q, level_d;
    logic [PPN_WIDTH-1:0]   base_q, base_d;
    logic                   abort_q, abort_d;
    logic                   done_q, done_d;
    logic                   pf_q, pf_d;
    logic                   af_q, af_d;
    logic [7:0]             bits_q, bits_d;
    logic [PPN_WIDTH-1:0]   pa_q, pa_d;
    logic [LW-1:0]          rlevel_q, rlevel_d;

    // PTE fields of the read data.
    logic [PPN_WIDTH-1:0]   pte_ppn;
    logic pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    assign pte_ppn = m_rdata[10 +: PPN_WIDTH];
    assign pte_v   = m_rdata[0];
    assign pte_r   = m_rdata[1];
    assign pte_w   = m_rdata[2];
    assign pte_x   = m_rdata[3];
    assign pte_u   = m_rdata[4];
    assign pte_a   = m_rdata[6];
    assign pte_d   = m_rdata[7];

    // RSW and any bits above the PPN carry no meaning for the walk.
    logic unused_pte;
    generate
        if (PTE_WIDTH > PPN_WIDTH + 10) begin : g_unused_hi
            assign unused_pte = ^{m_rdata[PTE_WIDTH-1:PPN_WIDTH+10], m_rdata[9:8]};
        end else begin : g_unused_rsw
            assign unused_pte = ^m_rdata[9:8];
        end
    endgenerate

    // VPN slice indexed by the current level, and a mask of the PPN bits that
    // lie below that level (those come from the VA on a superpage hit).
    logic [VPN_BITS-1:0]  vpn_sel;
    logic [PPN_WIDTH-1:0] low_mask;
    always_comb begin
        vpn_sel  = '0;
        low_mask = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (level_q == LW'(i)) begin
                vpn_sel  = va_q[i*VPN_BITS +: VPN_BITS];
                low_mask = ~({PPN_WIDTH{1'b1}} << (i * VPN_BITS));
            end
        end
    end

    logic [PPN_WIDTH-1:0] va_ext;
    assign va_ext = PPN_WIDTH'(va_q);

    // Outcome of the PTE currently on m_rdata, in priority order.
    logic af_c, invalid_c, leaf_c, misaligned_c, ad_fault_c, ptr_fault_c, pf_c, descend_c;
    assign af_c         = (m_transaction_response != RESP_SUCCESS);
    assign invalid_c    = !pte_v || (!pte_r && pte_w);
    assign leaf_c       = pte_r || pte_x;
    assign misaligned_c = |(pte_ppn & low_mask);
    assign ad_fault_c   = CHECK_AD && (!pte_a || (store_q && !pte_d));
    assign ptr_fault_c  = (level_q == '0) || pte_d || pte_a || pte_u;
    assign pf_c         = !af_c && (invalid_c ||
                                    (leaf_c && (misaligned_c || ad_fault_c)) ||
                                    (!leaf_c && ptr_fault_c));
    assign descend_c    = !af_c && !invalid_c && !leaf_c && !ptr_fault_c;

    always_comb begin
        state_d  = state_q;
        va_d     = va_q;
        store_d  = store_q;
        level_d  = level_q;
        base_d   = base_q;
        abort_d  = abort_q;
        done_d   = 1'b0;
        pf_d     = 1'b0;
        af_d     = 1'b0;
        bits_d   = bits_q;
        pa_d     = pa_q;
        rlevel_d = rlevel_q;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (resolve_request) begin
                    va_d    = virtual_address;
                    store_d = resolve_store;
                    level_d = LW'(LEVELS - 1);
                    base_d  = satp_ppn;
                    if (satp_mode) begin
                        state_d = WALK;
                    end else begin
                        // Bare mode: identity map with full permissions.
                        state_d  = RESP;
                        done_d   = 1'b1;
                        bits_d   = 8'hCF;
                        pa_d     = PPN_WIDTH'(virtual_address);
                        rlevel_d = '0;
                    end
                end
            end
            WALK: begin
                if (resolve_abort) begin
                    abort_d = 1'b1;
                end
                if (m_transaction_done) begin
                    if (abort_q || resolve_abort) begin
                        // Outstanding read has retired; drop the walk silently.
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else if (descend_c) begin
                        level_d = level_q - 1'b1;
                        base_d  = pte_ppn;
                    end else begin
                        state_d  = RESP;
                        done_d   = 1'b1;
                        af_d     = af_c;
                        pf_d     = pf_c;
                        rlevel_d = level_q;
                        if (af_c || pf_c) begin
                            bits_d = 8'h00;
                            pa_d   = '0;
                        end else begin
                            bits_d = m_rdata[7:0];
                            pa_d   = (pte_ppn & ~low_mask) | (va_ext & low_mask);
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            va_q     <= '0;
            store_q  <= 1'b0;
            level_q  <= '0;
            base_q   <= '0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
            pf_q     <= 1'b0;
            af_q     <= 1'b0;
            bits_q   <= 8'h00;
            pa_q     <= '0;
            rlevel_q <= '0;
        end else begin
            state_q  <= state_d;
            va_q     <= va_d;
            store_q  <= store_d;
            level_q  <= level_d;
            base_q   <= base_d;
            abort_q  <= abort_d;
            done_q   <= done_d;
            pf_q     <= pf_d;
            af_q     <= af_d;
            bits_q   <= bits_d;
            pa_q     <= pa_d;
            rlevel_q <= rlevel_d;
        end
    end

    assign m_transaction            = (state_q == WALK);
    assign m_cmd                    = CMD_READ;
    assign m_address                = {base_q, vpn_sel, {PTE_SHIFT{1'b0}}};
    assign resolve_ack              = (state_q == IDLE);
    assign resolve_done             = done_q;
    assign resolve_pagefault        = pf_q;
    assign resolve_accessfault      = af_q;
    assign resolve_access_bits      = bits_q;
    assign resolve_physical_address = pa_q;
    assign resolve_level            = rlevel_q;
endmodule

// File: tb/tb_corevx_ptw_ml.sv
// Testbench for corevx_ptw_ml: an Sv32 instance and an Sv39 instance share
// one set of stimulus variables; sel39 picks which one is driven/observed.
module tb_corevx_ptw_ml;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel39 = 1'b0;
    logic        req = 1'b0, abort = 1'b0, store = 1'b0, satp_mode = 1'b1;
    logic [63:0] va = '0, satp_ppn = '0, bus_rdata = '0;
    logic        bus_done = 1'b0;
    logic [2:0]  bus_resp = '0;

    always #5 clk = ~clk;

    // Sv32 instance signals
    logic        mt32, ack32, done32, pf32, af32;
    logic [2:0]  cmd32;
    logic [33:0] addr32;
    logic [7:0]  bits32;
    logic [21:0] pa32;
    logic [0:0]  lvl32;
    // Sv39 instance signals
    logic        mt39, ack39, done39, pf39, af39;
    logic [2:0]  cmd39;
    logic [55:0] addr39;
    logic [7:0]  bits39;
    logic [43:0] pa39;
    logic [1:0]  lvl39;

    corevx_ptw_ml u_sv32 (
        .clk(clk), .rst_n(rst_n),
        .m_transaction(mt32), .m_cmd(cmd32), .m_address(addr32),
        .m_transaction_response(bus_resp), .m_transaction_done(bus_done & ~sel39),
        .m_rdata(bus_rdata[31:0]),
        .resolve_request(req & ~sel39), .resolve_ack(ack32),
        .resolve_abort(abort & ~sel39), .resolve_store(store),
        .virtual_address(va[19:0]), .satp_mode(satp_mode), .satp_ppn(satp_ppn[21:0]),
        .resolve_done(done32), .resolve_pagefault(pf32), .resolve_accessfault(af32),
        .resolve_access_bits(bits32), .resolve_physical_address(pa32),
        .resolve_level(lvl32)
    );

    corevx_ptw_ml #(.LEVELS(3), .VPN_BITS(9), .PPN_WIDTH(44), .PTE_WIDTH(64)) u_sv39 (
        .clk(clk), .rst_n(rst_n),
        .m_transaction(mt39), .m_cmd(cmd39), .m_address(addr39),
        .m_transaction_response(bus_resp), .m_transaction_done(bus_done & sel39),
        .m_rdata(bus_rdata),
        .resolve_request(req & sel39), .resolve_ack(ack39),
        .resolve_abort(abort & sel39), .resolve_store(store),
        .virtual_address(va[26:0]), .satp_mode(satp_mode), .satp_ppn(satp_ppn[43:0]),
        .resolve_done(done39), .resolve_pagefault(pf39), .resolve_accessfault(af39),
        .resolve_access_bits(bits39), .resolve_physical_address(pa39),
        .resolve_level(lvl39)
    );

    logic        o_mt, o_ack, o_done, o_pf, o_af;
    logic [2:0]  o_cmd;
    logic [63:0] o_addr, o_pa;
    logic [7:0]  o_bits;
    logic [1:0]  o_lvl;
    assign o_mt   = sel39 ? mt39   : mt32;
    assign o_ack  = sel39 ? ack39  : ack32;
    assign o_done = sel39 ? done39 : done32;
    assign o_pf   = sel39 ? pf39   : pf32;
    assign o_af   = sel39 ? af39   : af32;
    assign o_cmd  = sel39 ? cmd39  : cmd32;
    assign o_addr = sel39 ? 64'(addr39) : 64'(addr32);
    assign o_pa   = sel39 ? 64'(pa39)   : 64'(pa32);
    assign o_bits = sel39 ? bits39 : bits32;
    assign o_lvl  = sel39 ? lvl39  : {1'b0, lvl32};

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    typedef struct {
        logic            s39;
        logic [63:0]     va;
        logic            st;
        int              n;
        logic [2:0][63:0] addr;
        logic [2:0][63:0] rd;
        logic [2:0]      resp0;
        logic            pf;
        logic            af;
        logic [7:0]      bits;
        logic [63:0]     pa;
        logic [1:0]      lvl;
    } vec_t;

    function automatic vec_t mk(input logic s39, input logic [63:0] v, input logic st, input int n,
                                input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2,
                                input logic [63:0] r0, input logic [63:0] r1, input logic [63:0] r2,
                                input logic [2:0] rsp, input logic pf, input logic af,
                                input logic [7:0] bits, input logic [63:0] pa, input logic [1:0] lvl);
        vec_t t;
        t.s39 = s39; t.va = v; t.st = st; t.n = n;
        t.addr[0] = a0; t.addr[1] = a1; t.addr[2] = a2;
        t.rd[0] = r0; t.rd[1] = r1; t.rd[2] = r2;
        t.resp0 = rsp; t.pf = pf; t.af = af; t.bits = bits; t.pa = pa; t.lvl = lvl;
        return t;
    endfunction

    // One paged walk: each read answered one cycle after it appears.
    task automatic run_vec(input vec_t v, input int id);
        int w;
        sel39 = v.s39; satp_mode = 1'b1; satp_ppn = 64'h100; va = v.va; store = v.st;
        req = 1'b1;
        chk($sformatf("v%0d ack", id), {63'd0, o_ack}, 64'd1);
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            w = 0;
            while (!o_mt && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("v%0d r%0d mt", id, k), {63'd0, o_mt}, 64'd1);
            chk($sformatf("v%0d r%0d addr", id, k), o_addr, v.addr[k]);
            @(negedge clk);
            chk($sformatf("v%0d r%0d addr_hold", id, k), o_addr, v.addr[k]);
            chk($sformatf("v%0d r%0d cmd", id, k), {61'd0, o_cmd}, 64'd1);
            bus_done = 1'b1; bus_rdata = v.rd[k]; bus_resp = (k == 0) ? v.resp0 : 3'd0;
            @(negedge clk);
            bus_done = 1'b0; bus_resp = 3'd0;
            if (k < v.n - 1)
                chk($sformatf("v%0d r%0d early_done", id, k), {63'd0, o_done}, 64'd0);
        end
        chk($sformatf("v%0d done", id), {63'd0, o_done}, 64'd1);
        chk($sformatf("v%0d pf", id), {63'd0, o_pf}, {63'd0, v.pf});
        chk($sformatf("v%0d af", id), {63'd0, o_af}, {63'd0, v.af});
        chk($sformatf("v%0d bits", id), {56'd0, o_bits}, {56'd0, v.bits});
        chk($sformatf("v%0d pa", id), o_pa, v.pa);
        chk($sformatf("v%0d lvl", id), {62'd0, o_lvl}, {62'd0, v.lvl});
        chk($sformatf("v%0d ack_in_resp", id), {63'd0, o_ack}, 64'd0);
        $display("txn v%0d: done=%0b pf=%0b af=%0b bits=%h pa=%h lvl=%0d",
                 id, o_done, o_pf, o_af, o_bits, o_pa, o_lvl);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", id), {63'd0, o_done}, 64'd0);
        chk($sformatf("v%0d fault_pulse", id), {62'd0, o_pf, o_af}, 64'd0);
    endtask

    localparam logic [63:0] PTR32 = 64'h00080001;
    vec_t vecs[12];

    initial begin
        vecs[0]  = mk(0, 64'h00401, 0, 2, 64'h100004, 64'h200004, 0, PTR32, 64'h048D14CF, 0, 3'd0, 0, 0, 8'hCF, 64'h12345, 0);
        vecs[1]  = mk(0, 64'h00401, 0, 1, 64'h100004, 0, 0, 64'h001000CF, 0, 0, 3'd0, 0, 0, 8'hCF, 64'h401, 1);
        vecs[2]  = mk(0, 64'h00401, 0, 1, 64'h100004, 0, 0, 64'h001004CF, 0, 0, 3'd0, 1, 0, 8'h00, 64'h0, 1);
        vecs[3]  = mk(0, 64'h00401, 0, 1, 64'h100004, 0, 0, 64'h048D14CF, 0, 0, 3'd3, 0, 1, 8'h00, 64'h0, 1);
        vecs[4]  = mk(0, 64'h00401, 0, 1, 64'h100004, 0, 0, 64'h00000004, 0, 0, 3'd0, 1, 0, 8'h00, 64'h0, 1);
        vecs[5]  = mk(0, 64'h00401, 0, 2, 64'h100004, 64'h200004, 0, PTR32, PTR32, 0, 3'd0, 1, 0, 8'h00, 64'h0, 0);
        vecs[6]  = mk(0, 64'h00401, 1, 2, 64'h100004, 64'h200004, 0, PTR32, 64'h048D144F, 0, 3'd0, 1, 0, 8'h00, 64'h0, 0);
        vecs[7]  = mk(0, 64'h00802, 0, 2, 64'h100008, 64'h200008, 0, PTR32, 64'h048D144F, 0, 3'd0, 0, 0, 8'h4F, 64'h12345, 0);
        vecs[8]  = mk(0, 64'h00401, 0, 2, 64'h100004, 64'h200004, 0, PTR32, 64'h048D140F, 0, 3'd0, 1, 0, 8'h00, 64'h0, 0);
        vecs[9]  = mk(0, 64'h00401, 0, 1, 64'h100004, 0, 0, 64'h00080041, 0, 0, 3'd0, 1, 0, 8'h00, 64'h0, 1);
        vecs[10] = mk(1, 64'h40403, 0, 3, 64'h100008, 64'h200010, 64'h300018,
                      64'h80001, 64'hC0001, (64'hABCDE12 << 10) | 64'hCF, 3'd0, 0, 0, 8'hCF, 64'hABCDE12, 0);
        vecs[11] = mk(1, 64'h40403, 0, 2, 64'h100008, 64'h200010, 0,
                      64'h80001, (64'h5000 << 10) | 64'hCF, 0, 3'd0, 0, 0, 8'hCF, 64'h5003, 1);

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel39 = s[0];
            #1;
            chk($sformatf("rst%0d mt", s), {63'd0, o_mt}, 64'd0);
            chk($sformatf("rst%0d ack", s), {63'd0, o_ack}, 64'd1);
            chk($sformatf("rst%0d flags", s), {61'd0, o_done, o_pf, o_af}, 64'd0);
            chk($sformatf("rst%0d bits", s), {56'd0, o_bits}, 64'd0);
            chk($sformatf("rst%0d pa", s), o_pa, 64'd0);
            chk($sformatf("rst%0d lvl", s), {62'd0, o_lvl}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Bare mode: no bus access, result one cycle after accept.
        sel39 = 1'b0; satp_mode = 1'b0; va = 64'hABCDE; store = 1'b0; req = 1'b1;
        chk("bare ack", {63'd0, o_ack}, 64'd1);
        @(negedge clk);
        req = 1'b0;
        chk("bare done", {63'd0, o_done}, 64'd1);
        chk("bare mt", {63'd0, o_mt}, 64'd0);
        chk("bare pa", o_pa, 64'h0ABCDE);
        chk("bare bits", {56'd0, o_bits}, 64'hCF);
        chk("bare lvl", {62'd0, o_lvl}, 64'd0);
        chk("bare faults", {62'd0, o_pf, o_af}, 64'd0);
        $display("txn bare: done=%0b pa=%h bits=%h", o_done, o_pa, o_bits);
        @(negedge clk);
        chk("bare mt_after", {63'd0, o_mt}, 64'd0);
        chk("bare done_pulse", {63'd0, o_done}, 64'd0);
        satp_mode = 1'b1;

        // Abort two cycles into a read whose done arrives five cycles in.
        va = 64'h00401; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("abort mt c%0d", c), {63'd0, o_mt}, 64'd1);
            abort = (c == 2);
            @(negedge clk);
        end
        abort = 1'b0;
        bus_done = 1'b1; bus_rdata = PTR32;
        @(negedge clk);
        bus_done = 1'b0;
        chk("abort mt_drop", {63'd0, o_mt}, 64'd0);
        chk("abort no_done", {63'd0, o_done}, 64'd0);
        chk("abort ack", {63'd0, o_ack}, 64'd1);
        @(negedge clk);
        chk("abort no_done2", {63'd0, o_done}, 64'd0);
        chk("abort no_reissue", {63'd0, o_mt}, 64'd0);
        $display("txn abort: dropped, ack=%0b", o_ack);
        run_vec(vecs[0], 100);

        // Abort coinciding with the completing read.
        va = 64'h00401; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        abort = 1'b1; bus_done = 1'b1; bus_rdata = 64'h001000CF;
        @(negedge clk);
        abort = 1'b0; bus_done = 1'b0;
        chk("abort_same no_done", {63'd0, o_done}, 64'd0);
        chk("abort_same ack", {63'd0, o_ack}, 64'd1);
        chk("abort_same mt", {63'd0, o_mt}, 64'd0);
        $display("txn abort_same: dropped");

        // Sv39 reset in the middle of a walk (previous result still held).
        sel39 = 1'b1; va = 64'h40403; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("rstwalk mt", {63'd0, o_mt}, 64'd1);
        chk("rstwalk held_pa", o_pa, 64'h5003);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwalk mt_drop", {63'd0, o_mt}, 64'd0);
        chk("rstwalk ack", {63'd0, o_ack}, 64'd1);
        chk("rstwalk pa", o_pa, 64'd0);
        chk("rstwalk bits", {56'd0, o_bits}, 64'd0);
        chk("rstwalk lvl", {62'd0, o_lvl}, 64'd0);
        $display("txn reset_mid_walk: mt=%0b pa=%h", o_mt, o_pa);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[10], 110);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/corevx_ptw_ml.md
Name: corevx_ptw_ml

Overview:
Parametrised multi-level page table walker; the next generation of the two-level Sv32 walker, now covering Sv39-style configurations through parameters. It translates a VPN to a leaf PPN over an armleobus read master port. New over the previous walker:
- A/D and store-dirty checking.
- Bare-mode passthrough.
- Walk abort.
- Registered results with a leaf-level report for superpage-aware TLB fill.

Parameters:
LEVELS, 2, page table levels (2 = Sv32, 3 = Sv39).
VPN_BITS, 10, VPN slice width per level.
PPN_WIDTH, 22, physical page number width.
PTE_WIDTH, 32, PTE width in bits. Static check: VPN_BITS + log2(PTE_WIDTH/8) == 12, else elaboration error.
CHECK_AD, 1, enable the A/D fault checks.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
m_transaction  out  1  bus request; held until m_transaction_done
m_cmd  out  3  constant ARMLEOBUS_CMD_READ
m_address  out  PPN_WIDTH+12  PTE address = {table_base, vpn[level], zeros}
m_transaction_response  in  3  bus response
m_transaction_done  in  1  bus completion strobe
m_rdata  in  PTE_WIDTH  PTE read data
resolve_request  in  1  walk request
resolve_ack  out  1  request accepted (high when state==IDLE)
resolve_abort  in  1  cancel the walk in progress
resolve_store  in  1  walk is for a store (D check); sampled on accept
virtual_address  in  LEVELS*VPN_BITS  VPN; sampled on accept
satp_mode  in  1  0 = bare, 1 = paged; sampled on accept
satp_ppn  in  PPN_WIDTH  root table PPN; sampled on accept
resolve_done  out  1  one-cycle result pulse
resolve_pagefault  out  1  valid with resolve_done
resolve_accessfault  out  1  valid with resolve_done
resolve_access_bits  out  8  PTE[7:0] of the leaf (DAGUXWRV)
resolve_physical_address  out  PPN_WIDTH  translated PPN
resolve_level  out  max(1,clog2(LEVELS))  level of the leaf (0 = 4 KiB page)

Behaviour:
Reset and states:
- Reset: state = IDLE, resolve_done/pagefault/accessfault = 0, access_bits = 0, physical_address = 0, level = 0.
- States: IDLE, WALK, RESP.
- Result outputs are registered and hold until the next RESP.

IDLE:
- resolve_ack = 1.
- On resolve_request: latch VA, store flag, satp fields; set level = LEVELS-1, base = satp_ppn.
- If satp_mode = 1: go to WALK.
- If satp_mode = 0: go to RESP directly, no bus access. Result: PPN = zero-extended VA, access_bits = 8'hCF, level = 0, no fault.

WALK:
- m_transaction = 1; m_address is stable for the whole transaction.
- On m_transaction_done, evaluate in priority order:
  1. Response != SUCCESS → accessfault.
  2. V = 0, or (R = 0 and W = 1) → pagefault.
  3. Leaf (R or X set):
     - Misaligned (level > 0 and any PPN slice below the level nonzero) → pagefault.
     - Else if CHECK_AD and (A = 0, or store and D = 0) → pagefault.
     - Else success.
  4. Non-leaf:
     - level == 0, or any of D/A/U set → pagefault.
     - Otherwise level -= 1, base = PTE PPN; stay in WALK and issue the next read the following cycle.
- Every terminal outcome goes to RESP and latches the result.

PTE and result formation:
- PTE PPN = m_rdata[10 +: PPN_WIDTH].
- Slice i is VPN_BITS wide for i < LEVELS-1; the top slice takes the remainder.
- Success PPN: slices below the leaf level come from the VA, the rest from the PTE.
- On any fault: access_bits = 0, PPN = 0, level = current level.

RESP:
- resolve_done = 1 for exactly one cycle; the fault flags are asserted only in this cycle.
- Next state is IDLE.
- Latency: paged = (sum of bus latencies) + 1 cycle after the final done; bare = 1 cycle after accept.

Abort:
- resolve_abort in WALK sets abort_pending. The outstanding transaction must complete.
- When its m_transaction_done arrives, go to IDLE without resolve_done; no further reads are issued.
- Abort in the same cycle as m_transaction_done: result dropped, go to IDLE.
- Abort is ignored in IDLE and RESP.

Other rules:
- Request in RESP: not acknowledged; it is accepted on the following IDLE cycle.
- Reset mid-walk: go to IDLE immediately; m_transaction drops the next cycle.

Test Plan:
1. Sv32 defaults, satp_ppn = 22'h00100, VA = 20'h00401.
   - First read at 0x100004, rdata 32'h00080001 (pointer).
   - Second read at 0x200004, rdata 32'h048D14CF.
   - Required: done with no fault, PPN = 22'h012345, access_bits = 8'hCF, level = 0.
2. Megapage: same request, first rdata 32'h001000CF → PPN = 22'h000401, level = 1, one bus read only. With rdata 32'h001004CF → pagefault (misaligned).
3. Faults:
   - Response error on first read → accessfault only, access_bits = 0.
   - rdata 32'h00000004 (W without R) → pagefault.
   - Pointer at level 0 → pagefault.
   - CHECK_AD = 1, store, leaf 32'h048D144F (D = 0) → pagefault.
4. Bare mode: satp_mode = 0, VA = 20'hABCDE → resolve_done 1 cycle after accept, PPN = 22'h0ABCDE, m_transaction never asserted.
5. Abort: assert resolve_abort 2 cycles into the first read with done delayed 5 cycles. Required: m_transaction stays high until done, no resolve_done, ack returns; a following request completes normally.
6. LEVELS = 3, VPN_BITS = 9, PTE_WIDTH = 64, PPN_WIDTH = 44:
   - Three-read 4 KiB walk yields the expected PPN.
   - Level-1 leaf with zero PPN[8:0] → level = 1.
   - Reset asserted mid-walk → IDLE, outputs zero.
